// File: rtl/mac_accumulator.sv
// Signed 4x4 multiply-accumulate over a programmable number of terms (1..16),
// with a valid/ready beat input and a held result that waits for a consumer handshake.
module mac_accumulator #(
    parameter int unsigned ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       len,
    input  logic             clear,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int unsigned PROD_W = 8;
    localparam int unsigned EXT_W  = ACC_W - PROD_W;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic signed [PROD_W-1:0] prod_c;
    logic [CNT_W-1:0]         cnt_inc_c;

    // Both operands are sign-extended to 8 bits so -8*-8 = +64 stays exact.
    always_comb begin
        prod_c    = $signed({{4{a[3]}}, a}) * $signed({{4{b[3]}}, b});
        cnt_inc_c = cnt_q + CNT_W'(1);
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = (len == 4'd0) ? CNT_W'(16) : CNT_W'(len);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (in_valid) begin
                    acc_d = acc_q + {{EXT_W{prod_c[PROD_W-1]}}, prod_c};
                    cnt_d = cnt_inc_c;
                    if (cnt_inc_c == len_q) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over every other transition.
        if (clear) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end

        in_ready_d  = (state_d == S_ACC);
        out_valid_d = (state_d == S_HOLD);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = acc_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: expected results are queued by the stimulus
// and consumed by a monitor on each out_valid/out_ready handshake.
module tb_mac_accumulator;

    localparam int unsigned ACC_W = 20;

    logic             clk;
    logic             rst;
    logic             start;
    logic [3:0]       len;
    logic             clear;
    logic [3:0]       a;
    logic [3:0]       b;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] result;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    int n_cmp;
    int n_err;
    logic [ACC_W-1:0] exp_q[$];

    mac_accumulator #(.ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .clear     (clear),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [3:0] av, input logic [3:0] bv);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Monitor: one pop per result handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: got 0x%0h with empty queue", result);
                end else begin
                    check("result_handshake", 32'(result), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; start = 1'b0; len = 4'd0; clear = 1'b0;
        a = 4'd0; b = 4'd0; in_valid = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_result",    32'(result),    32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        rst = 1'b0;
        tick();

        // len=1, 3 * -2 = -6
        do_start(4'd1);
        check("s1_in_ready", 32'(in_ready), 32'd1);
        check("s1_busy_acc", 32'(busy), 32'd1);
        exp_q.push_back(20'hFFFFA);
        beat(4'd3, 4'hE);
        check("s1_out_valid", 32'(out_valid), 32'd1);
        check("s1_result", 32'(result), 32'hFFFFA);
        check("s1_busy_hold", 32'(busy), 32'd1);
        check("s1_in_ready_hold", 32'(in_ready), 32'd0);
        tick();
        check("s1_idle_out_valid", 32'(out_valid), 32'd0);
        check("s1_idle_busy", 32'(busy), 32'd0);
        check("s1_idle_result_kept", 32'(result), 32'hFFFFA);

        // len=0 means 16 terms of -8*-8 = 1024
        do_start(4'd0);
        exp_q.push_back(20'h00400);
        a = 4'h8; b = 4'h8; in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 14) check("s2_not_done_after_15", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        check("s2_out_valid", 32'(out_valid), 32'd1);
        check("s2_result", 32'(result), 32'h00400);
        tick();

        // len=3 with idle gaps: 49 - 56 - 1 = -8
        do_start(4'd3);
        exp_q.push_back(20'hFFFF8);
        for (int k = 0; k < 3; k++) begin
            a = 4'h5; b = 4'h5; in_valid = 1'b0;
            tick();
            tick();
            case (k)
                0: beat(4'd7, 4'd7);
                1: beat(4'h8, 4'd7);
                default: beat(4'd1, 4'hF);
            endcase
        end
        check("s3_out_valid", 32'(out_valid), 32'd1);
        check("s3_result", 32'(result), 32'hFFFF8);
        tick();
        beat(4'd7, 4'd7);
        check("s3_no_extra_beat", 32'(result), 32'hFFFF8);
        check("s3_idle_busy", 32'(busy), 32'd0);

        // HOLD back-pressure with start and len toggling: 1 + 6 = 7
        do_start(4'd2);
        out_ready = 1'b0;
        exp_q.push_back(20'd7);
        beat(4'd1, 4'd1);
        beat(4'd2, 4'd3);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            len   = 4'(i);
            check("s4_hold_valid", 32'(out_valid), 32'd1);
            check("s4_hold_result", 32'(result), 32'd7);
            tick();
        end
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        check("s4_idle_out_valid", 32'(out_valid), 32'd0);
        check("s4_start_ignored", 32'(busy), 32'd0);
        check("s4_result_kept", 32'(result), 32'd7);

        // Async reset mid-accumulation discards partial sum
        do_start(4'd4);
        beat(4'd3, 4'd3);
        beat(4'd3, 4'd3);
        check("s5_partial", 32'(result), 32'd18);
        #1 rst = 1'b1;
        #1;
        check("s5_async_result", 32'(result), 32'd0);
        check("s5_async_busy", 32'(busy), 32'd0);
        check("s5_async_in_ready", 32'(in_ready), 32'd0);
        check("s5_async_out_valid", 32'(out_valid), 32'd0);
        #1 rst = 1'b0;
        tick();
        beat(4'd1, 4'd1);
        check("s5_needs_start", 32'(busy), 32'd0);
        do_start(4'd1);
        exp_q.push_back(20'd4);
        beat(4'd2, 4'd2);
        check("s5_result", 32'(result), 32'd4);
        tick();

        // clear together with a valid beat
        do_start(4'd2);
        beat(4'd1, 4'd1);
        clear = 1'b1;
        beat(4'd5, 4'd5);
        clear = 1'b0;
        check("s6_busy", 32'(busy), 32'd0);
        check("s6_result", 32'(result), 32'd0);
        check("s6_out_valid", 32'(out_valid), 32'd0);

        tick();
        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 The parameter list SHALL be: ACC_W, 20, accumulator/result width in bits (legal range 12..32).
REQ-002 The port list SHALL be as follows, one port per line:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  begin a new accumulation.
- len  input  4  number of terms; 1..15 literal, 0 means 16.
- clear  input  1  synchronous abort to IDLE.
- a  input  4  signed two's-complement operand.
- b  input  4  signed two's-complement operand.
- in_valid  input  1  a/b beat is valid.
- in_ready  output  1  block accepts a beat.
- result  output  ACC_W  signed accumulated sum.
- out_valid  output  1  result is final.
- out_ready  input  1  consumer accepts result.
- busy  output  1  state is not IDLE.

Function
REQ-003 The block SHALL implement three states: IDLE, ACC and HOLD.
REQ-004 IDLE SHALL drive in_ready=0 and out_valid=0; start=1 SHALL latch len (0 mapped to 16), clear the accumulator and the term counter, and move to ACC on the next edge.
REQ-005 ACC SHALL drive in_ready=1; a beat SHALL be accepted on any edge where in_valid=1 and in_ready=1; in_valid=0 cycles SHALL leave all state unchanged.
REQ-006 Each accepted beat SHALL form the signed 8-bit product a*b, with range -56..+64 (-8*-8=+64 is exact).
REQ-007 Each accepted beat SHALL sign-extend that product by replicating bit 7 to ACC_W bits and add it to the accumulator, wrapping modulo 2^ACC_W.
REQ-008 No overflow SHALL be possible at ACC_W>=12, since the maximum magnitude is 16*64=1024.
REQ-009 The term counter SHALL increment per accepted beat; acceptance of the len-th beat SHALL move the state to HOLD on that same edge, so out_valid=1 appears in the cycle after the last beat (latency 1).
REQ-010 HOLD SHALL drive out_valid=1 and in_ready=0; result SHALL remain stable until out_ready=1 is sampled, and the state SHALL then return to IDLE on that edge.
REQ-011 result SHALL always equal the accumulator register and SHALL keep its value in IDLE until the next start.
REQ-012 start SHALL be ignored in ACC and HOLD; start coinciding with the out_ready handshake in HOLD SHALL be ignored, and a new start is required in IDLE.
REQ-013 len SHALL be sampled only on start acceptance; changes to len at any other time SHALL have no effect.
REQ-014 clear=1 SHALL force IDLE on the next edge from any state, zeroing the accumulator and the counter; clear SHALL take priority over start, beat acceptance and out_ready.
REQ-015 busy SHALL be 1 in ACC and HOLD and 0 in IDLE.
REQ-016 a and b SHALL be ignored whenever in_ready=0.

Reset
REQ-017 rst=1 SHALL immediately, without waiting for a clock edge, force the state to IDLE, the accumulator to 0, the counter to 0 and the latched len to 0, and drive in_ready=0, out_valid=0, busy=0 and result=0.
REQ-018 Reset mid-ACC or mid-HOLD SHALL discard the partial sum; the first action after rst deasserts SHALL require a new start.

Verification
REQ-019 The bench SHALL cover the following scenarios (ACC_W=20):
- start with len=1; beat a=3, b=-2 -> out_valid=1 next cycle, result=0xFFFFA (-6), busy=1.
- start with len=0; 16 beats of a=-8, b=-8 -> out_valid after beat 16, result=0x00400 (1024).
- start with len=3; beats (7,7), (-8,7), (1,-1) separated by 2 idle in_valid=0 cycles -> result=0xFFFF8 (-8), exactly 3 beats accepted.
- In HOLD, out_ready=0 for 5 cycles with start pulsed -> result and out_valid stable; out_ready=1 -> IDLE, out_valid=0 next cycle.
- rst pulsed between edges after 2 of 4 beats -> outputs 0 asynchronously; a new start with len=1 and beat (2,2) -> result=4.
- clear asserted together with a valid beat in ACC -> IDLE next edge, result=0, beat not accumulated.
